// File: rtl/spi_reg_slave.sv
// -----------------------------------------------------------------------------
// spi_reg_slave
//
// SPI Mode-0 responder that converts 40-bit host frames (8-bit command, then
// DATA_W data bits, MSB first) into single-cycle register-bus strobes in the
// clk domain. The SPI pins are oversampled through SYNC_STAGES flops, so the
// block has a single clock domain (clk).
//
// Command byte: bit7 = 1 write, bit7 = 0 read, bits[6:0] register address.
// The first byte shifted out on miso is the status byte left behind by the
// previous frame: {5'b0, rd_late, overrun, abort}.
//
// Ports:
//   clk         system clock (at least 8x the SCK frequency)
//   rstn        asynchronous active-low reset
//   spi_sck     SPI clock, CPOL = 0
//   spi_ss_n    SPI select, active low
//   spi_mosi    host-to-slave data
//   spi_miso    slave-to-host data, 0 while deselected
//   reg_addr    register address, valid with reg_rd / reg_wr
//   reg_wdata   write data, valid with reg_wr
//   reg_wr      one-clk write strobe
//   reg_rd      one-clk read strobe
//   reg_rdata   read data, sampled when reg_rvalid = 1
//   reg_rvalid  read data valid, same cycle as reg_rd or later
//   busy        high while a frame is in progress
// -----------------------------------------------------------------------------
module spi_reg_slave #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              spi_sck,
    input  logic              spi_ss_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_rvalid,
    output logic              busy
);

    localparam int FRAME_LEN = 8 + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);

    // Counter values of interest: the counter holds the number of rising
    // edges seen so far in the frame and parks at FRAME_LEN + 1.
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_CMD_M1   = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_CMD      = CNT_W'(8);
    localparam logic [CNT_W-1:0] CNT_LAST_M1  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(FRAME_LEN + 1);

    // Synchronizer chains and one-clk-delayed copies for edge detection
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_d;
    logic                   ss_d;

    logic sck_s;
    logic ss_s;
    logic mosi_s;

    // Frame state
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] shift_in;
    logic [DATA_W-2:0] shift_out;
    logic [7:0]        cmd_q;
    logic              rd_wait;
    logic              rd_got;
    logic [DATA_W-1:0] rdata_q;
    logic              flag_abort;
    logic              flag_overrun;
    logic              flag_rd_late;
    logic [2:0]        status_q;

    // Decoded events
    logic              sck_rise;
    logic              sck_fall;
    logic              frame_start;
    logic              frame_end;
    logic [7:0]        cmd_next;
    logic [7:0]        status_byte;
    logic              read_hit;
    logic [DATA_W-1:0] read_word;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // The select chain resets to 0 (selected) on purpose: a select that is
    // already low when reset is released never produces a falling edge, so
    // that frame is ignored until the host deselects and selects again.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_sync  <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            ss_d      <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_d     <= sck_s;
            ss_d      <= ss_s;
        end
    end

    // SCK edges only count inside an active frame; busy doubles as the
    // "frame open" flag so stray edges while deselected are dropped.
    always_comb begin
        sck_rise    = busy & ~ss_s & sck_s & ~sck_d;
        sck_fall    = busy & ~ss_s & ~sck_s & sck_d;
        frame_start = ~busy & ss_d & ~ss_s;
        frame_end   = busy & ss_s;
        cmd_next    = {shift_in[6:0], mosi_s};
        status_byte = {5'b0, status_q};
        // Read data may arrive in the very clk that the response is loaded
        read_hit    = rd_got | (rd_wait & reg_rvalid);
        read_word   = '0;
        if (rd_got) begin
            read_word = rdata_q;
        end else if (rd_wait && reg_rvalid) begin
            read_word = reg_rdata;
        end
    end

    // Frame engine: bit counting, shifting, strobes, per-frame flags and the
    // status byte handed to the next frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            spi_miso     <= 1'b0;
            reg_addr     <= '0;
            reg_wdata    <= '0;
            reg_wr       <= 1'b0;
            reg_rd       <= 1'b0;
            busy         <= 1'b0;
            bit_cnt      <= '0;
            shift_in     <= '0;
            shift_out    <= '0;
            cmd_q        <= '0;
            rd_wait      <= 1'b0;
            rd_got       <= 1'b0;
            rdata_q      <= '0;
            flag_abort   <= 1'b0;
            flag_overrun <= 1'b0;
            flag_rd_late <= 1'b0;
            status_q     <= '0;
        end else begin
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;

            // Only the first valid beat after reg_rd is kept
            if (rd_wait && reg_rvalid) begin
                rdata_q <= reg_rdata;
                rd_got  <= 1'b1;
                rd_wait <= 1'b0;
            end

            if (frame_start) begin
                busy         <= 1'b1;
                bit_cnt      <= '0;
                cmd_q        <= '0;
                rd_wait      <= 1'b0;
                rd_got       <= 1'b0;
                flag_abort   <= 1'b0;
                flag_overrun <= 1'b0;
                flag_rd_late <= 1'b0;
                spi_miso     <= status_byte[7];
                shift_out    <= {status_byte[6:0], {(DATA_W-8){1'b0}}};
            end else if (frame_end) begin
                busy     <= 1'b0;
                spi_miso <= 1'b0;
                rd_wait  <= 1'b0;
                status_q <= {flag_rd_late, flag_overrun, (bit_cnt < CNT_LAST)};
            end else begin
                if (sck_rise) begin
                    shift_in <= {shift_in[DATA_W-3:0], mosi_s};
                    if (bit_cnt != CNT_SAT) begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                    if (bit_cnt >= CNT_LAST) begin
                        flag_overrun <= 1'b1;
                    end
                    // Command complete: reads are issued immediately so the
                    // register file has until the 8th falling edge to answer.
                    if (bit_cnt == CNT_CMD_M1) begin
                        cmd_q <= cmd_next;
                        if (!cmd_next[7]) begin
                            reg_addr <= cmd_next[ADDR_W-1:0];
                            reg_rd   <= 1'b1;
                            rd_wait  <= 1'b1;
                            rd_got   <= 1'b0;
                        end
                    end
                    if (bit_cnt == CNT_LAST_M1 && cmd_q[7]) begin
                        reg_addr  <= cmd_q[ADDR_W-1:0];
                        reg_wdata <= {shift_in, mosi_s};
                        reg_wr    <= 1'b1;
                    end
                end

                if (sck_fall) begin
                    if (bit_cnt == CNT_CMD) begin
                        rd_wait <= 1'b0;
                        if (!cmd_q[7]) begin
                            spi_miso  <= read_word[DATA_W-1];
                            shift_out <= read_word[DATA_W-2:0];
                            if (!read_hit) begin
                                flag_rd_late <= 1'b1;
                            end
                        end else begin
                            spi_miso  <= 1'b0;
                            shift_out <= '0;
                        end
                    end else if (bit_cnt >= CNT_LAST) begin
                        spi_miso <= 1'b0;
                    end else begin
                        spi_miso  <= shift_out[DATA_W-2];
                        shift_out <= {shift_out[DATA_W-3:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_slave
//
// Self-checking bench for spi_reg_slave. An SPI host task drives Mode-0
// frames, a register-file responder answers reg_rd with a programmable
// reg_rvalid latency, and a frame-level reference model predicts the bytes
// the host receives, the strobes issued and the status byte for the next
// frame.
// -----------------------------------------------------------------------------
module tb_spi_reg_slave;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        spi_sck;
    logic        spi_ss_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic [6:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] reg_rdata = 32'h0;
    logic        reg_rvalid = 1'b0;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    // Register-file responder state and strobe observations
    int          rd_count = 0;
    int          wr_count = 0;
    logic [6:0]  rd_addr_seen = '0;
    logic [6:0]  wr_addr_seen = '0;
    logic [31:0] wr_data_seen = '0;
    int          rv_delay = -1;
    int          rv_count = 0;
    logic [31:0] rv_data = '0;

    // Reference model state: status byte the next frame should present
    logic [7:0]  exp_status = 8'h00;

    always #5 clk = ~clk;

    spi_reg_slave #(
        .ADDR_W      (7),
        .DATA_W      (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .spi_sck    (spi_sck),
        .spi_ss_n   (spi_ss_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .busy       (busy)
    );

    // Register file: counts every clk a strobe is high, and answers a read
    // after rv_delay clks (0 = same clk as reg_rd, negative = never). Outside
    // the valid beat reg_rdata carries noise.
    always @(negedge clk) begin
        reg_rvalid = 1'b0;
        if (rv_count > 0) begin
            rv_count = rv_count - 1;
            if (rv_count == 0) reg_rvalid = 1'b1;
        end
        if (reg_rd === 1'b1) begin
            rd_count     = rd_count + 1;
            rd_addr_seen = reg_addr;
            if (rv_delay == 0) reg_rvalid = 1'b1;
            else if (rv_delay > 0) rv_count = rv_delay;
        end
        if (reg_wr === 1'b1) begin
            wr_count     = wr_count + 1;
            wr_addr_seen = reg_addr;
            wr_data_seen = reg_wdata;
        end
        reg_rdata = reg_rvalid ? rv_data : $urandom();
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // SPI host: bit i of the frame is tx[63-i]; the miso value present at
    // each rising sck edge lands in rx[63-i].
    task automatic do_frame(input int nbits, input logic [63:0] tx,
                            output logic [63:0] rx, output logic busy_mid);
        rx       = '0;
        busy_mid = 1'b0;
        spi_ss_n = 1'b0;
        wait_clk(6);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[63-i];
            wait_clk(HALF);
            rx[63-i] = spi_miso;
            spi_sck  = 1'b1;
            if (i == nbits / 2) busy_mid = busy;
            wait_clk(HALF);
            spi_sck = 1'b0;
        end
        wait_clk(6);
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(8);
    endtask

    // Frame-level reference model: predicts what the host receives, which
    // strobes fire, and the status byte the following frame will show.
    task automatic model_frame(input int nbits, input logic [7:0] cmd,
                               input int delay, input logic [31:0] rdata,
                               output logic [63:0] exp_rx, output logic [63:0] mask,
                               output int exp_rd, output int exp_wr);
        bit          is_write;
        bit          on_time;
        logic [31:0] word;
        is_write = cmd[7];
        on_time  = (delay >= 0) && (delay <= 4);
        exp_rd   = (!is_write && nbits >= 8) ? 1 : 0;
        exp_wr   = (is_write && nbits >= 40) ? 1 : 0;
        word     = (exp_rd == 1 && on_time) ? rdata : 32'h0;
        exp_rx   = {exp_status, word, 24'h0};
        mask     = (nbits == 0) ? 64'h0 : (~64'h0 << (64 - nbits));
        exp_status = {5'b0, (exp_rd == 1 && !on_time), (nbits > 40), (nbits < 40)};
    endtask

    task automatic run_frame(input int nbits, input logic [7:0] cmd, input logic [31:0] data,
                             input int delay, input logic [31:0] rdata,
                             output logic [63:0] rx, output logic busy_mid,
                             output int d_rd, output int d_wr);
        int rd0;
        int wr0;
        rv_delay = delay;
        rv_data  = rdata;
        rd0      = rd_count;
        wr0      = wr_count;
        do_frame(nbits, {cmd, data, 24'h0}, rx, busy_mid);
        d_rd     = rd_count - rd0;
        d_wr     = wr_count - wr0;
        rv_delay = -1;
    endtask

    // Outputs straight after reset release
    task automatic test_reset();
        rstn     = 1'b0;
        spi_sck  = 1'b0;
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(5);
        rstn = 1'b1;
        wait_clk(5);
        vectors++;
        if ({spi_miso, reg_wr, reg_rd, busy} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %b want 0000", {spi_miso, reg_wr, reg_rd, busy});
        end
        vectors++;
        if (reg_addr !== 7'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_addr: got %h want 00", reg_addr);
        end
        vectors++;
        if (reg_wdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_wdata: got %h want 00000000", reg_wdata);
        end
    endtask

    // FREQ_1 = 1000 write
    task automatic test_write();
        logic [63:0] rx, exp_rx, mask;
        logic        bm;
        int          d_rd, d_wr, e_rd, e_wr;
        model_frame(40, 8'h81, -1, 32'h0, exp_rx, mask, e_rd, e_wr);
        run_frame(40, 8'h81, 32'h0000_03E8, -1, 32'h0, rx, bm, d_rd, d_wr);
        vectors++;
        if (d_wr !== e_wr || d_rd !== e_rd) begin
            miscompares++;
            $display("[TB] FAIL write_strobes: got wr=%0d rd=%0d want wr=%0d rd=%0d", d_wr, d_rd, e_wr, e_rd);
        end
        vectors++;
        if (wr_addr_seen !== 7'h01 || wr_data_seen !== 32'h0000_03E8) begin
            miscompares++;
            $display("[TB] FAIL write_payload: got %h/%h want 01/000003e8", wr_addr_seen, wr_data_seen);
        end
        vectors++;
        if (bm !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL write_busy: got mid=%b after=%b want 1/0", bm, busy);
        end
        vectors++;
        if ((rx & mask) !== (exp_rx & mask)) begin
            miscompares++;
            $display("[TB] FAIL write_miso: got %h want %h", rx & mask, exp_rx & mask);
        end
    endtask

    // Read of address 0 answered one clk after reg_rd; status after write = 0
    task automatic test_read();
        logic [63:0] rx, exp_rx, mask;
        logic        bm;
        int          d_rd, d_wr, e_rd, e_wr;
        model_frame(40, 8'h00, 1, 32'h3202_4003, exp_rx, mask, e_rd, e_wr);
        run_frame(40, 8'h00, 32'h0, 1, 32'h3202_4003, rx, bm, d_rd, d_wr);
        vectors++;
        if (d_rd !== 1 || d_wr !== 0 || rd_addr_seen !== 7'h00) begin
            miscompares++;
            $display("[TB] FAIL read_strobe: got rd=%0d wr=%0d addr=%h want 1/0/00", d_rd, d_wr, rd_addr_seen);
        end
        vectors++;
        if (rx[63:56] !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL read_status: got %h want 00", rx[63:56]);
        end
        vectors++;
        if (rx[55:24] !== 32'h3202_4003 || (rx & mask) !== (exp_rx & mask)) begin
            miscompares++;
            $display("[TB] FAIL read_data: got %h want 32024003", rx[55:24]);
        end
    endtask

    // reg_rvalid never arrives: zeros returned, rd_late reported next frame
    task automatic test_read_late();
        logic [63:0] rx, exp_rx, mask;
        logic        bm;
        int          d_rd, d_wr, e_rd, e_wr;
        model_frame(40, 8'h05, -1, 32'hDEAD_BEEF, exp_rx, mask, e_rd, e_wr);
        run_frame(40, 8'h05, 32'h0, -1, 32'hDEAD_BEEF, rx, bm, d_rd, d_wr);
        vectors++;
        if (rx[55:24] !== 32'h0 || d_rd !== 1) begin
            miscompares++;
            $display("[TB] FAIL late_data: got %h rd=%0d want 00000000 rd=1", rx[55:24], d_rd);
        end
        model_frame(40, 8'h00, 0, 32'h1234_5678, exp_rx, mask, e_rd, e_wr);
        run_frame(40, 8'h00, 32'h0, 0, 32'h1234_5678, rx, bm, d_rd, d_wr);
        vectors++;
        if (rx[63:56] !== 8'h04 || (rx & mask) !== (exp_rx & mask)) begin
            miscompares++;
            $display("[TB] FAIL late_status: got %h want 04 (frame %h)", rx[63:56], exp_rx);
        end
    endtask

    // Write abandoned after 20 bits: no strobe, abort reported once
    task automatic test_abort();
        logic [63:0] rx, exp_rx, mask;
        logic        bm;
        int          d_rd, d_wr, e_rd, e_wr;
        model_frame(20, 8'h85, -1, 32'h0, exp_rx, mask, e_rd, e_wr);
        run_frame(20, 8'h85, 32'hCAFE_F00D, -1, 32'h0, rx, bm, d_rd, d_wr);
        vectors++;
        if (d_wr !== 0 || d_rd !== 0) begin
            miscompares++;
            $display("[TB] FAIL abort_strobe: got wr=%0d rd=%0d want 0/0", d_wr, d_rd);
        end
        for (int k = 0; k < 2; k++) begin
            model_frame(40, 8'h81, -1, 32'h0, exp_rx, mask, e_rd, e_wr);
            run_frame(40, 8'h81, 32'h0000_0001, -1, 32'h0, rx, bm, d_rd, d_wr);
            vectors++;
            if (rx[63:56] !== ((k == 0) ? 8'h01 : 8'h00) || rx[63:56] !== exp_rx[63:56]) begin
                miscompares++;
                $display("[TB] FAIL abort_status%0d: got %h want %h", k, rx[63:56], (k == 0) ? 8'h01 : 8'h00);
            end
        end
    endtask

    // 48-bit write: the write stands, extra bits read as zero, overrun flagged
    task automatic test_overrun();
        logic [63:0] rx, exp_rx, mask;
        logic        bm;
        int          d_rd, d_wr, e_rd, e_wr;
        model_frame(48, 8'h82, -1, 32'h0, exp_rx, mask, e_rd, e_wr);
        run_frame(48, 8'h82, 32'h0F0F_0F0F, -1, 32'h0, rx, bm, d_rd, d_wr);
        vectors++;
        if (d_wr !== 1 || wr_addr_seen !== 7'h02 || wr_data_seen !== 32'h0F0F_0F0F) begin
            miscompares++;
            $display("[TB] FAIL overrun_write: got n=%0d %h/%h want 1 02/0f0f0f0f", d_wr, wr_addr_seen, wr_data_seen);
        end
        vectors++;
        if (rx[23:16] !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL overrun_tail: got %h want 00", rx[23:16]);
        end
        model_frame(40, 8'h03, 2, 32'h0000_00AA, exp_rx, mask, e_rd, e_wr);
        run_frame(40, 8'h03, 32'h0, 2, 32'h0000_00AA, rx, bm, d_rd, d_wr);
        vectors++;
        if (rx[63:56] !== 8'h02 || (rx & mask) !== (exp_rx & mask)) begin
            miscompares++;
            $display("[TB] FAIL overrun_status: got %h want 02", rx[63:56]);
        end
    endtask

    // rstn pulsed at bit 30 of a write; the remainder of that frame is ignored
    task automatic test_reset_midframe();
        logic [63:0] tx, rx, exp_rx, mask;
        logic        bm;
        logic        busy_any;
        int          wr0, d_rd, d_wr, e_rd, e_wr;
        tx       = {8'h83, 32'h5555_AAAA, 24'h0};
        wr0      = wr_count;
        busy_any = 1'b0;
        spi_ss_n = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 40; i++) begin
            if (i == 30) begin
                rstn = 1'b0;
                #2;
                vectors++;
                if ({spi_miso, reg_wr, reg_rd, busy, reg_addr, reg_wdata} !== 43'h0) begin
                    miscompares++;
                    $display("[TB] FAIL midreset_outputs: got miso=%b wr=%b rd=%b busy=%b addr=%h wdata=%h want all 0",
                             spi_miso, reg_wr, reg_rd, busy, reg_addr, reg_wdata);
                end
                wait_clk(3);
                rstn = 1'b1;
            end
            spi_mosi = tx[63-i];
            wait_clk(HALF);
            spi_sck = 1'b1;
            if (i > 30) busy_any = busy_any | busy;
            wait_clk(HALF);
            spi_sck = 1'b0;
        end
        wait_clk(6);
        spi_ss_n = 1'b1;
        wait_clk(8);
        vectors++;
        if (wr_count != wr0 || busy_any !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_ignored: got wr=%0d busy=%b want 0/0", wr_count - wr0, busy_any);
        end
        exp_status = 8'h00;
        model_frame(40, 8'h83, -1, 32'h0, exp_rx, mask, e_rd, e_wr);
        run_frame(40, 8'h83, 32'h1357_9BDF, -1, 32'h0, rx, bm, d_rd, d_wr);
        vectors++;
        if (d_wr !== 1 || wr_data_seen !== 32'h1357_9BDF || rx[63:56] !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL midreset_next: got wr=%0d data=%h status=%h want 1/13579bdf/00",
                     d_wr, wr_data_seen, rx[63:56]);
        end
    endtask

    // Random frames: lengths, commands, data and read latencies
    task automatic test_random();
        logic [63:0] rx, exp_rx, mask;
        logic        bm;
        logic [7:0]  cmd;
        logic [31:0] data, rdata;
        int          nbits, delay, sel, d_rd, d_wr, e_rd, e_wr;
        for (int n = 0; n < 16; n++) begin
            sel   = $urandom_range(0, 9);
            nbits = (sel <= 5 || sel == 9) ? 40 :
                    (sel == 6) ? $urandom_range(41, 48) :
                    (sel == 7) ? $urandom_range(9, 39) : $urandom_range(1, 8);
            sel   = $urandom_range(0, 6);
            delay = (sel <= 4) ? sel : (sel == 5) ? -1 : $urandom_range(10, 14);
            cmd   = 8'($urandom());
            data  = $urandom();
            rdata = $urandom();
            model_frame(nbits, cmd, delay, rdata, exp_rx, mask, e_rd, e_wr);
            run_frame(nbits, cmd, data, delay, rdata, rx, bm, d_rd, d_wr);
            vectors++;
            if ((rx & mask) !== (exp_rx & mask)) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_miso: n=%0d cmd=%h dly=%0d got %h want %h",
                         n, nbits, cmd, delay, rx & mask, exp_rx & mask);
            end
            vectors++;
            if (d_rd !== e_rd || d_wr !== e_wr) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_strobes: got rd=%0d wr=%0d want rd=%0d wr=%0d",
                         n, d_rd, d_wr, e_rd, e_wr);
            end
            if (e_wr == 1) begin
                vectors++;
                if (wr_addr_seen !== cmd[6:0] || wr_data_seen !== data) begin
                    miscompares++;
                    $display("[TB] FAIL rand%0d_wpayload: got %h/%h want %h/%h",
                             n, wr_addr_seen, wr_data_seen, cmd[6:0], data);
                end
            end
            if (e_rd == 1) begin
                vectors++;
                if (rd_addr_seen !== cmd[6:0]) begin
                    miscompares++;
                    $display("[TB] FAIL rand%0d_raddr: got %h want %h", n, rd_addr_seen, cmd[6:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_late();
        test_abort();
        test_overrun();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
- SPI Mode-0 responder (slave) that turns host SPI frames into single-cycle register-bus read/write strobes in the clk domain.
- Sits between the board SPI pins and the register file of the transform core (FREQ_n, EN_CORDIC, STATUS, DATA_n, VERSION, DEBUG).
- SPI inputs are oversampled and synchronized into clk, so no SCK clock domain exists.
- Each frame is a 40-bit transaction: 8-bit command followed by 32-bit data, MSB first.

Parameters:
- ADDR_W, 7, register address width. Fixed by the command byte; must be ≤7.
- DATA_W, 32, register data width. Frame length = 8 + DATA_W.
- SYNC_STAGES, 2, flop stages on spi_sck, spi_ss_n and spi_mosi. Must be ≥2.

Ports:
- clk  in  1  system clock. Must be ≥8x SCK frequency.
- rstn  in  1  asynchronous active-low reset.
- spi_sck  in  1  SPI clock, CPOL=0.
- spi_ss_n  in  1  SPI select, active low.
- spi_mosi  in  1  host to slave data.
- spi_miso  out  1  slave to host data. Driven 0 while deselected.
- reg_addr  out  ADDR_W  register address. Valid with reg_rd/reg_wr.
- reg_wdata  out  DATA_W  write data. Valid with reg_wr.
- reg_wr  out  1  one-clk write strobe.
- reg_rd  out  1  one-clk read strobe.
- reg_rdata  in  DATA_W  read data. Sampled when reg_rvalid=1.
- reg_rvalid  in  1  read data valid. May coincide with reg_rd or come later.
- busy  out  1  high while a frame is in progress (synchronized ss_n low).

Behaviour:
- Reset values: spi_miso=0, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, busy=0, bit counter=0, status byte=0.
- Synchronization and edge detection: inputs pass SYNC_STAGES flops. A rise or fall of synced sck is detected one clk after the sync output.
- All actions below key on detected edges while synced ss_n=0.
- Frame start (synced ss_n falls):
  - bit counter cleared, busy set.
  - shift-out register loaded with status byte {5'b0, rd_late, overrun, abort} from the previous frame.
  - spi_miso = status bit7 on the next clk.
- Rising sck: shift in mosi, increment counter. Counting saturates at 41.
- Falling sck: shift out next miso bit.
- Command byte: bit7=1 means write, bit7=0 means read; bits[6:0] are the address.
- Read path:
  - On the 8th rising edge with cmd=read: reg_addr set and reg_rd pulsed for exactly 1 clk.
  - rdata is captured on the first reg_rvalid at or after the reg_rd pulse.
  - On the 8th falling edge, the shift-out register loads the captured rdata and miso drives bit31.
  - If reg_rvalid has not arrived by then: load 0 and set rd_late.
  - A reg_rvalid that arrives later in the frame is ignored.
- Write path:
  - On the 40th rising edge with cmd=write: reg_addr and reg_wdata set, reg_wr pulsed 1 clk.
  - Outputs are registered, so reg_wr is high in the clk after edge detect.
- During the write data phase miso shifts 0.
- Bits beyond 40: ignored, miso=0, overrun set. A write already issued at bit 40 stands.
- Synced ss_n rises with counter <40: abort set, no reg_wr. A reg_rd already issued is not retracted.
- Frame end (synced ss_n rises):
  - busy cleared, spi_miso=0.
  - the new status byte is latched from this frame's flags. Flags are per frame and are not accumulated.
- SCK edges while ss_n is high: ignored.
- ss_n high pulses shorter than SYNC_STAGES+1 clk are not guaranteed to be seen.
- rstn assertion mid-frame: everything returns to reset values immediately, no strobe is emitted.
  - After rstn release, a frame whose ss_n is already low is ignored until ss_n rises.
- Timing requirements:
  - Host must allow ≥4 clk from ss_n fall to the first sck rise.
  - Host must allow ≥4 clk from the last sck fall to ss_n rise.
  - The register file must return reg_rvalid within (half SCK period − SYNC_STAGES − 2) clk of reg_rd.

Test Plan:
- Write: cmd 0x81, data 0x0000_03E8 (FREQ_1=1000), 40 bits → exactly one reg_wr, reg_addr=0x01, reg_wdata=0x000003E8. Status byte in the following frame = 0x00.
- Read with reg_rvalid 1 clk after reg_rd, rdata=0x3202_4003, cmd 0x00 → one reg_rd with reg_addr=0x00. Host captures 0x32024003 on miso bits 8..39.
- Read where reg_rvalid never arrives → host reads 0x00000000. Next frame's first miso byte = 0x04 (rd_late).
- Aborted write: ss_n raised after 20 bits of cmd 0x85 → no reg_wr. Next frame status byte = 0x01. The frame after that = 0x00.
- Overrun: 48-bit frame, cmd 0x82, data 0x0F0F0F0F → reg_wr with 0x0F0F0F0F. miso=0 for bits 40..47. Next status byte = 0x02.
- rstn pulsed mid-frame at bit 30 of a write → no reg_wr, all outputs 0. The next complete frame is processed normally.
